// File: rtl/sy_ppl_fetch_ctrl_pkg.sv
// Shared types and sizing for the front-end fetch controller.
package sy_ppl_fetch_ctrl_pkg;

    localparam int INSTR_PER_FETCH  = 2;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int CREDIT_MAX       = 2 * FETCH_FIFO_DEPTH - 2;
    localparam int MAX_OUTSTANDING  = 2;
    localparam int FETCH_BYTES      = 8;

    localparam int CREDIT_W = $clog2(CREDIT_MAX + 1);
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_e;

    // Number of valid lanes in a fetch response mask.
    function automatic logic [CREDIT_W-1:0] lane_popcount(input logic [INSTR_PER_FETCH-1:0] mask);
        logic [CREDIT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            cnt = cnt + CREDIT_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sy_ppl_fetch_ctrl_if.sv
// I$ request/response and instruction-buffer control signals of the fetch controller.
interface sy_ppl_fetch_ctrl_if;
    import sy_ppl_fetch_ctrl_pkg::*;

    logic                       icache_req_o;
    logic [63:0]                icache_addr_o;
    logic                       icache_gnt_i;
    logic                       icache_rsp_valid_i;
    logic [INSTR_PER_FETCH-1:0] icache_rsp_mask_i;
    logic                       icache_rsp_ex_i;
    logic [INSTR_PER_FETCH-1:0] buf_valid_o;
    logic                       buf_ex_o;
    logic                       buf_ready_i;
    logic                       dec_pop_i;

    // Fetch controller side
    modport master (
        output icache_req_o, icache_addr_o, buf_valid_o, buf_ex_o,
        input  icache_gnt_i, icache_rsp_valid_i, icache_rsp_mask_i, icache_rsp_ex_i,
               buf_ready_i, dec_pop_i
    );

    // I$ / instruction buffer / decode side
    modport slave (
        input  icache_req_o, icache_addr_o, buf_valid_o, buf_ex_o,
        output icache_gnt_i, icache_rsp_valid_i, icache_rsp_mask_i, icache_rsp_ex_i,
               buf_ready_i, dec_pop_i
    );

endinterface

// File: rtl/sy_ppl_fetch_ctrl_credit.sv
// Buffer-space credit counter: reserves worst-case slots per request,
// returns unused lanes, frees one slot per decode pop, reloads on flush.
module sy_ppl_fetch_credit
    import sy_ppl_fetch_ctrl_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_gnt,
    input  logic                       i_rsp_drop,
    input  logic                       i_rsp_fwd,
    input  logic [INSTR_PER_FETCH-1:0] i_rsp_mask,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [OUT_W-1:0]           i_flush_out,
    output logic [CREDIT_W-1:0]        o_credit
);

    localparam int SUM_W = CREDIT_W + 3;

    logic        [CREDIT_W-1:0] r_credit;
    logic signed [SUM_W-1:0]    w_sum;
    logic        [CREDIT_W-1:0] w_load;

    // Sum all same-cycle deltas with headroom so over/underflow is visible.
    always_comb begin
        w_sum = $signed({{(SUM_W-CREDIT_W){1'b0}}, r_credit});
        if (i_gnt)      w_sum = w_sum - SUM_W'(INSTR_PER_FETCH);
        if (i_rsp_drop) w_sum = w_sum + SUM_W'(INSTR_PER_FETCH);
        if (i_rsp_fwd)  w_sum = w_sum + SUM_W'(INSTR_PER_FETCH)
                              - $signed({{(SUM_W-CREDIT_W){1'b0}}, lane_popcount(i_rsp_mask)});
        if (i_pop)      w_sum = w_sum + SUM_W'(1);
        // Buffer is emptied by the flush; only still-outstanding requests keep their reservation.
        w_load = CREDIT_W'(CREDIT_MAX) - CREDIT_W'(INSTR_PER_FETCH) * CREDIT_W'(i_flush_out);
    end

    // Credit register: flush reload has priority over incremental update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit <= CREDIT_W'(CREDIT_MAX);
        end else if (i_flush) begin
            r_credit <= w_load;
        end else begin
            r_credit <= w_sum[CREDIT_W-1:0];
        end
    end

    // Credit must never leave [0, CREDIT_MAX].
    always_ff @(posedge clk_i) begin
        if (!rst_i && !i_flush) begin
            assert (w_sum >= 0 && w_sum <= SUM_W'(CREDIT_MAX));
        end
    end

    assign o_credit = r_credit;

endmodule

// File: rtl/sy_ppl_fetch_ctrl.sv
// Front-end fetch sequencer: PC generation, credit-gated I$ requests,
// stale-response dropping after flush, and response gating into the buffer.
module sy_ppl_fetch_ctrl
    import sy_ppl_fetch_ctrl_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      fetch_en_i,
    input  logic [63:0]               boot_pc_i,
    input  logic                      flush_i,
    input  logic [63:0]               redirect_pc_i,
    sy_ppl_fetch_ctrl_if.master       bus,
    output logic                      busy_o
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [63:0]           r_fetch_pc;
    logic [OUT_W-1:0]      r_out_cnt;
    logic [OUT_W-1:0]      r_drop_cnt;
    logic [OUT_W-1:0]      w_out_next;
    logic [OUT_W-1:0]      w_drop_next;
    logic [CREDIT_W-1:0]   w_credit;
    logic                  w_can_req;
    logic                  w_gnt;
    logic                  w_rsp;
    logic                  w_drop;
    logic                  w_fwd;

    // A grant in a flush cycle still creates an outstanding (stale) request,
    // so grant qualification ignores the flush withdrawal of req.
    assign w_can_req = (r_state == FETCH_RUN)
                    && (w_credit >= CREDIT_W'(INSTR_PER_FETCH))
                    && (r_out_cnt < OUT_W'(MAX_OUTSTANDING));
    assign w_gnt     = bus.icache_gnt_i && w_can_req;
    assign w_rsp     = bus.icache_rsp_valid_i;
    assign w_drop    = w_rsp && ((r_drop_cnt != '0) || flush_i);
    assign w_fwd     = w_rsp && !w_drop;
    assign w_out_next = r_out_cnt + OUT_W'(w_gnt) - OUT_W'(w_rsp);

    // Stale-response count: reloaded with everything outstanding on flush.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (flush_i) begin
            w_drop_next = w_out_next;
        end else if (w_drop && (r_drop_cnt != '0)) begin
            w_drop_next = r_drop_cnt - OUT_W'(1);
        end
    end

    sy_ppl_fetch_credit u_credit (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_gnt       (w_gnt),
        .i_rsp_drop  (w_drop),
        .i_rsp_fwd   (w_fwd),
        .i_rsp_mask  (bus.icache_rsp_mask_i),
        .i_pop       (bus.dec_pop_i),
        .i_flush     (flush_i),
        .i_flush_out (w_out_next),
        .o_credit    (w_credit)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= FETCH_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next-state: drain until every stale response has come back.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE:  if (fetch_en_i) w_state_next = FETCH_RUN;
            FETCH_RUN:   if (flush_i && (w_drop_next != '0)) w_state_next = FETCH_DRAIN;
            FETCH_DRAIN: if (w_drop_next == '0) w_state_next = FETCH_RUN;
            default:     w_state_next = FETCH_IDLE;
        endcase
    end

    // FSM outputs: request, buffer lane gating, busy.
    always_comb begin
        bus.icache_req_o = w_can_req && !flush_i;
        bus.buf_valid_o  = w_fwd ? bus.icache_rsp_mask_i : '0;
        bus.buf_ex_o     = w_fwd && bus.icache_rsp_ex_i;
        busy_o           = (r_state != FETCH_IDLE) || (r_out_cnt != '0);
    end

    assign bus.icache_addr_o = r_fetch_pc;

    // Fetch PC: boot load, redirect, or advance to the next aligned block on grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= '0;
        end else if (r_state == FETCH_IDLE) begin
            if (fetch_en_i) r_fetch_pc <= boot_pc_i;
        end else if (flush_i) begin
            r_fetch_pc <= redirect_pc_i;
        end else if (w_gnt) begin
            r_fetch_pc <= (r_fetch_pc & ~64'(FETCH_BYTES - 1)) + 64'(FETCH_BYTES);
        end
    end

    // Outstanding and stale counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_out_cnt  <= w_out_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    // Protocol checks: no orphan responses, no lanes pushed into a full buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_rsp && (r_out_cnt == '0)));
            assert (!((bus.buf_valid_o != '0) && !bus.buf_ready_i));
        end
    end

endmodule

// File: tb/tb_sy_ppl_fetch_ctrl.sv
// Scoreboard bench for sy_ppl_fetch_ctrl: directed scenarios then random traffic.
module tb_sy_ppl_fetch_ctrl;
    import sy_ppl_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [63:0] boot_pc = '0;
    logic        flush = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        busy;

    always #5 clk = ~clk;

    sy_ppl_fetch_ctrl_if bus();

    sy_ppl_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_en_i    (fetch_en),
        .boot_pc_i     (boot_pc),
        .flush_i       (flush),
        .redirect_pc_i (redirect_pc),
        .bus           (bus),
        .busy_o        (busy)
    );

    typedef struct {
        bit          chk;
        bit          req;
        logic [63:0] addr;
        logic [1:0]  bv;
        bit          bex;
        bit          busy;
        int          credit;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a list of outstanding requests (1 = stale), buffer occupancy, PC.
    bit          m_started;
    bit          m_q[$];
    int          m_occ;
    logic [63:0] m_pc;

    function automatic int m_credit();
        return CREDIT_MAX - INSTR_PER_FETCH * m_q.size() - m_occ;
    endfunction

    function automatic bit m_has_stale();
        foreach (m_q[i]) if (m_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_can_req();
        return m_started && !m_has_stale() && (m_credit() >= INSTR_PER_FETCH)
               && (m_q.size() < MAX_OUTSTANDING);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        fetch_en                 = 1'b0;
        flush                    = 1'b0;
        bus.icache_gnt_i         = 1'b0;
        bus.icache_rsp_valid_i   = 1'b0;
        bus.icache_rsp_mask_i    = '0;
        bus.icache_rsp_ex_i      = 1'b0;
        bus.dec_pop_i            = 1'b0;
        bus.buf_ready_i          = 1'b1;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '{chk: 1'b0, req: 1'b0, addr: '0, bv: '0, bex: 1'b0, busy: 1'b0, credit: 0};
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1;
            zero_inputs();
            sb.push_back(e);
        end
        m_started = 1'b0;
        m_q.delete();
        m_occ = 0;
        m_pc  = '0;
    endtask

    // One clock of stimulus; illegal requests are suppressed so the bench obeys the protocol.
    task automatic cycle(input bit en, input logic [63:0] bpc, input bit gnt, input bit rsp,
                         input logic [1:0] mask, input bit ex, input bit pop,
                         input bit fl, input logic [63:0] rpc);
        exp_t e;
        bit   drop;
        @(negedge clk);
        if (gnt && !m_can_req()) gnt = 1'b0;
        if (rsp && (m_q.size() == 0)) rsp = 1'b0;
        if (pop && (m_occ == 0)) pop = 1'b0;
        if (fl && !m_started) fl = 1'b0;
        rst                    = 1'b0;
        fetch_en               = en;
        boot_pc                = bpc;
        bus.icache_gnt_i       = gnt;
        bus.icache_rsp_valid_i = rsp;
        bus.icache_rsp_mask_i  = mask;
        bus.icache_rsp_ex_i    = ex;
        bus.dec_pop_i          = pop;
        bus.buf_ready_i        = 1'b1;
        flush                  = fl;
        redirect_pc            = rpc;

        drop     = rsp && (m_q[0] || fl);
        e.chk    = 1'b1;
        e.req    = m_can_req() && !fl;
        e.addr   = m_pc;
        e.busy   = m_started || (m_q.size() > 0);
        e.credit = m_credit();
        e.bv     = (rsp && !drop) ? mask : 2'b00;
        e.bex    = rsp && !drop && ex;
        sb.push_back(e);

        if (!m_started) begin
            if (en) begin
                m_started = 1'b1;
                m_pc      = bpc;
            end
        end else begin
            if (gnt) begin
                m_q.push_back(1'b0);
                m_pc = (m_pc & ~64'h7) + 64'd8;
            end
            if (rsp) begin
                void'(m_q.pop_front());
                if (!drop) m_occ += $countones(mask);
            end
            if (pop) m_occ -= 1;
            if (fl) begin
                foreach (m_q[i]) m_q[i] = 1'b1;
                m_occ = 0;
                m_pc  = rpc;
            end
        end
    endtask

    task automatic idle_c();
        cycle(0, '0, 0, 0, 2'b00, 0, 0, 0, '0);
    endtask
    task automatic gnt_c();
        cycle(0, '0, 1, 0, 2'b00, 0, 0, 0, '0);
    endtask
    task automatic rsp_c(input logic [1:0] mask);
        cycle(0, '0, 0, 1, mask, 0, 0, 0, '0);
    endtask
    task automatic pop_c();
        cycle(0, '0, 0, 0, 2'b00, 0, 1, 0, '0);
    endtask
    task automatic flush_c(input logic [63:0] rpc);
        cycle(0, '0, 0, 0, 2'b00, 0, 0, 1, rpc);
    endtask

    // Monitor: compares every presented output against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("icache_req",  64'(bus.icache_req_o), 64'(e.req));
                    check("icache_addr", bus.icache_addr_o,      e.addr);
                    check("buf_valid",   64'(bus.buf_valid_o),   64'(e.bv));
                    check("buf_ex",      64'(bus.buf_ex_o),      64'(e.bex));
                    check("busy",        64'(busy),              64'(e.busy));
                    check("credit",      64'(dut.w_credit),      64'(e.credit));
                end
            end
        end
    end

    initial begin : driver
        zero_inputs();
        do_reset();
        idle_c();                                   // reset state
        // Boot and first fetch addresses
        cycle(1, 64'h8000_0004, 0, 0, 2'b00, 0, 0, 0, '0);
        gnt_c();                                    // 0x8000_0004
        gnt_c();                                    // 0x8000_0008
        rsp_c(2'b11);
        gnt_c();                                    // 0x8000_0010, credit now 0
        rsp_c(2'b11);
        rsp_c(2'b11);
        idle_c();                                   // req low, credit 0
        pop_c();
        idle_c();                                   // one pop: req still low
        pop_c();
        idle_c();                                   // two pops: req high at 0x8000_0018
        // Partial response mask
        gnt_c();
        rsp_c(2'b01);
        idle_c();                                   // credit 1
        // Flush with two outstanding
        repeat (4) pop_c();
        gnt_c();
        gnt_c();
        flush_c(64'h1000);
        idle_c();
        rsp_c(2'b11);                               // dropped
        rsp_c(2'b11);                               // dropped
        idle_c();                                   // req at 0x1000, credit 6
        // Flush coinciding with grant and response
        gnt_c();
        cycle(0, '0, 1, 1, 2'b11, 0, 0, 1, 64'h2000);
        idle_c();                                   // credit 4
        rsp_c(2'b11);                               // dropped
        idle_c();                                   // req at 0x2000
        // Reset in the middle of a drain
        gnt_c();
        gnt_c();
        flush_c(64'h3000);
        do_reset();
        idle_c();
        idle_c();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle($urandom_range(0, 3) == 0, {$urandom, $urandom},
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4,
                  {$urandom, $urandom});
        end

        zero_inputs();
        repeat (2) @(negedge clk);
        #4;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
